ddr3_interface_sdpram: RTL and testbench

Simple dual-port synchronous RAM, 256 × 32 by default, used as a line/staging buffer between the video pipeline and the DDR3 controller. One port writes and one port reads, both in the same clock domain. Read data is registered, with an optional second output pipeline stage.

---
 rtl/ddr3_interface_sdpram_pkg.sv | 9 +
 rtl/ddr3_interface_sdpram.sv | 35 +++
 tb/tb_ddr3_interface_sdpram.sv | 99 +++++++++
 3 files changed

// File: rtl/ddr3_interface_sdpram_pkg.sv
// ddr3_interface_sdpram_pkg: shared defaults and helpers for the staging-buffer RAM
package ddr3_interface_sdpram_pkg;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 32;
  localparam bit DEF_OUTPUT_REG = 1'b0;
  function automatic int depth(input int aw);
    return 1 << aw;
  endfunction
endpackage

// File: rtl/ddr3_interface_sdpram.sv
// ddr3_interface_sdpram: simple dual-port RAM, read-first, 1 or 2 cycle registered read
module ddr3_interface_sdpram
  import ddr3_interface_sdpram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter bit OUTPUT_REG = DEF_OUTPUT_REG
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  localparam int DEPTH = depth(ADDR_WIDTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_stage_d, rd_stage_q;
  // array has no reset so it maps onto block RAM; the read register sees the pre-write word
  always_ff @(posedge clk)
    if (wr_en && !rst) mem[wr_addr] <= wr_data;
  always_comb rd_stage_d = rst ? '0 : mem[rd_addr];
  always_ff @(posedge clk) rd_stage_q <= rd_stage_d;
  generate
    if (OUTPUT_REG) begin : g_oreg
      logic [DATA_WIDTH-1:0] out_d, out_q;
      always_comb out_d = rst ? '0 : rd_stage_q;
      always_ff @(posedge clk) out_q <= out_d;
      assign rd_data = out_q;
    end else begin : g_noreg
      assign rd_data = rd_stage_q;
    end
  endgenerate
endmodule

// File: tb/tb_ddr3_interface_sdpram.sv
// tb_ddr3_interface_sdpram: checks both latency variants against a memory-array reference model
module tb_ddr3_interface_sdpram;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_en = 1'b0;
  logic [7:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [7:0] rd_addr = '0;
  logic [31:0] rd_data0, rd_data1;
  always #5 clk = ~clk;
  ddr3_interface_sdpram #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .OUTPUT_REG(1'b0)) u0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data0));
  ddr3_interface_sdpram #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .OUTPUT_REG(1'b1)) u1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data1));
  logic [31:0] mem_m [256];
  bit known [256];
  logic [31:0] v_prev, e0, e1;
  bit prev_ok, ok0, ok1;
  int n_chk = 0;
  int n_pass = 0;
  typedef struct {
    logic r, we;
    logic [7:0] wa;
    logic [31:0] wd;
    logic [7:0] ra;
    logic [31:0] x0, x1;
    bit m1;
  } vec_t;
  vec_t tbl [12];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  // one clock: apply inputs, advance the reference model, then compare both DUTs
  task automatic cyc(input logic r, input logic we, input logic [7:0] wa,
                     input logic [31:0] wd, input logic [7:0] ra);
    logic [31:0] val;
    bit vok;
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd; rd_addr = ra;
    @(posedge clk);
    val = r ? 32'h0 : mem_m[ra];
    vok = r || known[ra];
    e1 = r ? 32'h0 : v_prev;
    ok1 = r || prev_ok;
    e0 = val;
    ok0 = vok;
    v_prev = val;
    prev_ok = vok;
    if (we && !r) begin
      mem_m[wa] = wd;
      known[wa] = 1'b1;
    end
    #1;
    if (ok0) chk("model_lat1", rd_data0, e0);
    if (ok1) chk("model_lat2", rd_data1, e1);
  endtask
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_m[i] = '0;
      known[i] = 1'b0;
    end
    v_prev = '0;
    prev_ok = 1'b0;
    tbl[0]  = '{1'b0, 1'b1, 8'd5,   32'h1111_1111, 8'd9,   32'hFFFF_FFF6, 32'h0,         1'b0};
    tbl[1]  = '{1'b0, 1'b1, 8'd5,   32'h2222_2222, 8'd5,   32'h1111_1111, 32'hFFFF_FFF6, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 8'd7,   32'hDEAD_BEEF, 8'd5,   32'h2222_2222, 32'h1111_1111, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 8'd7,   32'hDEAD_BEEF, 8'd7,   32'hFFFF_FFF8, 32'h2222_2222, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 8'd0,   32'h0,         8'd8,   32'hFFFF_FFF7, 32'hFFFF_FFF8, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 8'd9,   32'h1234_5678, 8'd9,   32'h0,         32'h0,         1'b1};
    tbl[6]  = '{1'b0, 1'b0, 8'd0,   32'h0,         8'd9,   32'hFFFF_FFF6, 32'h0,         1'b1};
    tbl[7]  = '{1'b0, 1'b0, 8'd0,   32'h0,         8'd10,  32'hFFFF_FFF5, 32'hFFFF_FFF6, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 8'd255, 32'hAAAA_5555, 8'd1,   32'hFFFF_FFFE, 32'hFFFF_FFF5, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 8'd0,   32'h5555_AAAA, 8'd255, 32'hAAAA_5555, 32'hFFFF_FFFE, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 8'd0,   32'h0,         8'd0,   32'h5555_AAAA, 32'hAAAA_5555, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 8'd0,   32'h0,         8'd0,   32'h5555_AAAA, 32'h5555_AAAA, 1'b1};
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b0, 8'd0, 32'h0, 8'd0);
      chk("reset_lat1", rd_data0, 32'h0);
      chk("reset_lat2", rd_data1, 32'h0);
    end
    cyc(1'b0, 1'b0, 8'd0, 32'h0, 8'd0);
    chk("post_reset_lat2", rd_data1, 32'h0);
    for (int k = 0; k < 256; k++) cyc(1'b0, 1'b1, 8'(k), 32'hFFFF_FFFF - 32'(k), 8'd0);
    for (int k = 0; k < 258; k++) cyc(1'b0, 1'b0, 8'd0, 32'h0, 8'(k));
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].r, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra);
      chk($sformatf("vec%0d_lat1", i), rd_data0, tbl[i].x0);
      if (tbl[i].m1) chk($sformatf("vec%0d_lat2", i), rd_data1, tbl[i].x1);
    end
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(31) == 0, 1'($urandom), 8'($urandom), $urandom,
          ($urandom_range(3) == 0) ? wr_addr : 8'($urandom));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
